oam_dma_arbiter: RTL
====================

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning read-data latency in cycles of the shared memory port; only the value 1 is supported.
REQ-002 SHALL have ports (one per line: name  direction  width  meaning):
  clk  in  1  single clock; reset is synchronous and active-high
  rst  in  1  synchronous active-high reset
  cpu_addr  in  16  CPU address
  cpu_rd  in  1  CPU read strobe
  cpu_wr  in  1  CPU write strobe
  cpu_wdata  in  8  CPU write data
  cpu_rdata  out  8  CPU read data, one cycle after cpu_rd
  ppu_mode  in  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
  ppu_rd  in  1  PPU read strobe
  ppu_addr  in  16  PPU address
  ppu_rdata  out  8  PPU read data, one cycle after ppu_rd
  mem_addr  out  16  shared memory address
  mem_rd  out  1  shared memory read strobe
  mem_wr  out  1  shared memory write strobe
  mem_wdata  out  8  shared memory write data
  mem_rdata  in  8  shared memory read data, one cycle after mem_rd
  dma_active  out  1  high while an OAM DMA transfer is running

Function
REQ-003 SHALL arbitrate the single memory port for addresses 0000-FEFF with fixed priority DMA > PPU > CPU.
REQ-004 SHALL leave the memory port idle for CPU addresses FF00-FFFF; cpu_rdata SHALL read FF for these.
REQ-005 SHALL block a CPU access that meets any of these conditions: cpu_addr in 8000-9FFF with ppu_mode=DRAW; cpu_addr in FE00-FE9F with ppu_mode SCAN or DRAW; dma_active with cpu_addr < FF00.
REQ-006 SHALL drop a blocked or arbitration-losing CPU write and return FF for a blocked or losing CPU read in the response cycle.
REQ-007 SHALL return FF on ppu_rdata for any PPU read requested while dma_active.
REQ-008 SHALL register the owner of each read and route mem_rdata to the matching requester one cycle later; the non-owner SHALL see FF.
REQ-009 SHALL start a DMA when the CPU writes FF46: src_page = cpu_wdata, or cpu_wdata-0x20 when cpu_wdata >= E0.
REQ-010 SHALL implement the DMA FSM as IDLE -> START (1 cycle) -> READ -> WRITE -> READ ... -> IDLE.
REQ-011 DMA byte i (0..159) SHALL be transferred as: READ drives mem_rd=1 with mem_addr={src_page,i[7:0]}; the following WRITE drives mem_wr=1, mem_addr=FE00+i, mem_wdata=mem_rdata.
REQ-012 dma_active SHALL be high from START through the last WRITE and SHALL drop in the cycle after byte 159 is written.
REQ-013 An FF46 write while dma_active SHALL restart the transfer at i=0 with the new source, passing through START.
REQ-014 The byte counter SHALL be 8 bits and SHALL saturate the FSM to IDLE at 160, never wrapping.
REQ-015 mem_rd and mem_wr SHALL never be asserted in the same cycle.

Reset
REQ-016 rst SHALL force: FSM=IDLE, counter=0, dma_active=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, cpu_rdata=FF, ppu_rdata=FF.
REQ-017 rst during a transfer SHALL abort it with no further memory strobes; OAM keeps whatever bytes were already written.

Configuration
REQ-018 With macro DMA_MCYCLE_TIMING_EN defined, each byte SHALL take 4 cycles (READ, WRITE, WAIT, WAIT) for 640 transfer cycles, and the PPU or CPU MAY use the port during WAIT cycles.
REQ-019 Without DMA_MCYCLE_TIMING_EN, each byte SHALL take 2 cycles for 320 transfer cycles, and the WAIT state SHALL NOT exist.

Structure
REQ-020 Package ppu_pkg SHALL hold: the PPU mode enum (same encoding as ppu_mode); the DMA state typedef; address constants VRAM 8000/9FFF, OAM FE00/FE9F, DMA register FF46, OAM length 160.
REQ-021 The DMA FSM and counter SHALL be the sub-module oam_dma_engine; the top level SHALL hold the block/priority logic and response routing.

Verification
REQ-022 Write FF46=C1 in H_BLANK -> 160 reads C100-C19F, each paired with a write FE00-FE9F; dma_active stays high for 1+320 cycles (macro off) or 1+640 cycles (macro on).
REQ-023 CPU reads 9000 with ppu_mode=3 -> no mem_rd from CPU; cpu_rdata=FF next cycle. Same read with ppu_mode=0 -> mem_rdata returned.
REQ-024 PPU reads 9800 and CPU reads C000 in the same cycle, ppu_mode=0 -> mem_addr=9800; ppu_rdata=mem_rdata; cpu_rdata=FF.
REQ-025 FF46=C1, then FF46=D0 at byte 50 -> transfer restarts at i=0 reading D000; final OAM holds D000-D09F.
REQ-026 Write FF46=E2 -> source reads C200-C29F.
REQ-027 Assert rst at byte 80 -> next cycle mem_rd=mem_wr=0 and dma_active=0; CPU read of C000 is then served normally.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU-side types and constants for the memory arbiter and OAM DMA engine.
// DMA_MCYCLE_TIMING_EN adds two WAIT cycles per DMA byte (4-cycle byte timing).
package ppu_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_DRAW   = 2'd3
    } ppu_mode_t;

`ifdef DMA_MCYCLE_TIMING_EN
    typedef enum logic [2:0] {
        DMA_IDLE, DMA_START, DMA_READ, DMA_WRITE, DMA_WAIT1, DMA_WAIT2
    } dma_state_t;
    localparam dma_state_t DMA_BYTE_LAST = DMA_WAIT2;
`else
    typedef enum logic [1:0] {
        DMA_IDLE, DMA_START, DMA_READ, DMA_WRITE
    } dma_state_t;
    localparam dma_state_t DMA_BYTE_LAST = DMA_WRITE;
`endif

    typedef enum logic [1:0] {
        OWN_NONE, OWN_CPU, OWN_PPU, OWN_DMA
    } owner_t;

    localparam logic [15:0] VRAM_LO = 16'h8000;
    localparam logic [15:0] VRAM_HI = 16'h9FFF;
    localparam logic [15:0] OAM_LO  = 16'hFE00;
    localparam logic [15:0] OAM_HI  = 16'hFE9F;
    localparam logic [15:0] DMA_REG = 16'hFF46;
    localparam logic [15:0] IO_LO   = 16'hFF00;
    localparam logic [7:0]  OAM_LEN = 8'd160;

    // Pages E0-FF are echo RAM and fold back onto C0-DF.
    function automatic logic [7:0] dma_src_page(input logic [7:0] wdata);
        return (wdata >= 8'hE0) ? (wdata - 8'h20) : wdata;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: START, then READ/WRITE per byte for 160 bytes; restartable by start.
// With DMA_MCYCLE_TIMING_EN each byte also spends two WAIT cycles after its WRITE.
module oam_dma_engine
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_page,
    input  logic [7:0]  rdata,
    output logic        rd,
    output logic        wr,
    output logic [15:0] addr,
    output logic [7:0]  wdata,
    output logic        active
);

    dma_state_t state;
    logic [7:0] src_page;
    logic [7:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DMA_IDLE;
            idx      <= '0;
            src_page <= '0;
        end else if (start) begin
            state    <= DMA_START;
            idx      <= '0;
            src_page <= dma_src_page(start_page);
        end else begin
            case (state)
                DMA_START: state <= DMA_READ;
                DMA_READ:  state <= DMA_WRITE;
`ifdef DMA_MCYCLE_TIMING_EN
                DMA_WRITE: state <= DMA_WAIT1;
                DMA_WAIT1: state <= DMA_WAIT2;
`endif
                // Counter only advances while a byte is in flight, so it stops at 160.
                DMA_BYTE_LAST: begin
                    idx   <= idx + 8'd1;
                    state <= (idx == OAM_LEN - 8'd1) ? DMA_IDLE : DMA_READ;
                end
                default: state <= DMA_IDLE;
            endcase
        end
    end

    assign rd     = (state == DMA_READ);
    assign wr     = (state == DMA_WRITE);
    assign addr   = (state == DMA_READ) ? {src_page, idx} : {OAM_LO[15:8], idx};
    assign wdata  = rdata;
    assign active = (state != DMA_IDLE);

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shared memory port arbiter (DMA > PPU > CPU) with CPU access blocking and read routing.
// DMA_MCYCLE_TIMING_EN selects 4-cycle DMA byte timing in oam_dma_engine.
module oam_dma_arbiter
    import ppu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic [1:0]  ppu_mode,
    input  logic        ppu_rd,
    input  logic [15:0] ppu_addr,
    output logic [7:0]  ppu_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    logic        dma_rd;
    logic        dma_wr;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_start;
    logic        in_vram;
    logic        in_oam;
    logic        cpu_blocked;
    logic        cpu_req;
    logic        ppu_req;
    ppu_mode_t   mode;
    owner_t      owner_now;
    owner_t      owner_pipe [MEM_LAT];

    assign mode      = ppu_mode_t'(ppu_mode);
    assign dma_start = cpu_wr && (cpu_addr == DMA_REG);

    oam_dma_engine u_dma_engine (
        .clk        (clk),
        .rst        (rst),
        .start      (dma_start),
        .start_page (cpu_wdata),
        .rdata      (mem_rdata),
        .rd         (dma_rd),
        .wr         (dma_wr),
        .addr       (dma_addr),
        .wdata      (dma_wdata),
        .active     (dma_active)
    );

    assign in_vram     = (cpu_addr >= VRAM_LO) && (cpu_addr <= VRAM_HI);
    assign in_oam      = (cpu_addr >= OAM_LO) && (cpu_addr <= OAM_HI);
    assign cpu_blocked = (in_vram && mode == MODE_DRAW)
                      || (in_oam && (mode == MODE_SCAN || mode == MODE_DRAW))
                      || (dma_active && cpu_addr < IO_LO);
    assign cpu_req     = (cpu_rd || cpu_wr) && (cpu_addr < IO_LO) && !cpu_blocked;
    assign ppu_req     = ppu_rd && !dma_active;

    // Port is gated during rst so no strobe escapes while the engine is being cleared.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_now = OWN_NONE;
        if (!rst) begin
            if (dma_rd || dma_wr) begin
                mem_rd    = dma_rd;
                mem_wr    = dma_wr;
                mem_addr  = dma_addr;
                mem_wdata = dma_wr ? dma_wdata : 8'h00;
                owner_now = dma_rd ? OWN_DMA : OWN_NONE;
            end else if (ppu_req) begin
                mem_rd    = 1'b1;
                mem_addr  = ppu_addr;
                owner_now = OWN_PPU;
            end else if (cpu_req) begin
                mem_addr = cpu_addr;
                if (cpu_rd) begin
                    mem_rd    = 1'b1;
                    owner_now = OWN_CPU;
                end else begin
                    mem_wr    = 1'b1;
                    mem_wdata = cpu_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MEM_LAT; k++) owner_pipe[k] <= OWN_NONE;
        end else begin
            owner_pipe[0] <= owner_now;
            for (int k = 1; k < MEM_LAT; k++) owner_pipe[k] <= owner_pipe[k-1];
        end
    end

    assign cpu_rdata = (!rst && owner_pipe[MEM_LAT-1] == OWN_CPU) ? mem_rdata : 8'hFF;
    assign ppu_rdata = (!rst && owner_pipe[MEM_LAT-1] == OWN_PPU) ? mem_rdata : 8'hFF;

endmodule
